// File: rtl/mem_request_arbiter.sv
// Single-port memory arbiter: serializes instruction fetches and data
// loads/stores onto one RAM port, returns registered one-cycle hit strobes,
// keeps fetch from starving behind data traffic and bounds every access
// with a wait-cycle timeout that forces an error completion.
module mem_request_arbiter #(
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 15,
    parameter logic [DATA_W-1:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [DATA_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              ihit,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [DATA_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dhit,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [DATA_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              bus_err
);

    // RAM status codes; FREE (0) and BUSY (1) both simply mean "keep waiting".
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] IREAD  = 3'd1;
    localparam logic [2:0] DREAD  = 3'd2;
    localparam logic [2:0] DWRITE = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [2:0]       state_reg;
    logic [2:0]       grant_next;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             fair_reg;
    logic             in_access;
    logic             is_data;
    logic             done_ok;
    logic             done_err;
    logic             done;
    logic             granting;

    assign in_access = (state_reg == IREAD) || (state_reg == DREAD) || (state_reg == DWRITE);
    assign is_data   = (state_reg == DREAD) || (state_reg == DWRITE);
    // A valid ACCESS wins over a timeout that lands in the same cycle.
    assign done_ok   = in_access && (ramstate == RS_ACCESS);
    assign done_err  = in_access && !done_ok &&
                       ((ramstate == RS_ERROR) || (wait_cnt_reg == CNT_MAX));
    assign done      = done_ok || done_err;
    assign granting  = (state_reg == IDLE) && (grant_next != IDLE);

    // Arbitration priority in IDLE: owed fetch, write, read, fetch.
    always_comb begin
        grant_next = IDLE;
        if (fair_reg && iREN) begin
            grant_next = IREAD;
        end else if (dWEN) begin
            grant_next = DWRITE;
        end else if (dREN) begin
            grant_next = DREAD;
        end else if (iREN) begin
            grant_next = IREAD;
        end
    end

    // Main FSM: grant/latch, drive RAM strobes, complete with a registered hit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            ramREN    <= 1'b0;
            ramWEN    <= 1'b0;
            iload     <= '0;
            dload     <= '0;
            ramaddr   <= '0;
            ramstore  <= '0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (granting) begin
                        state_reg <= grant_next;
                        ramaddr   <= (grant_next == IREAD) ? iaddr : daddr;
                        ramstore  <= dstore;
                        ramREN    <= (grant_next != DWRITE);
                        ramWEN    <= (grant_next == DWRITE);
                    end
                end
                IREAD, DREAD, DWRITE: begin
                    if (done) begin
                        state_reg <= RESP;
                        ramREN    <= 1'b0;
                        ramWEN    <= 1'b0;
                        if (state_reg == IREAD) begin
                            ihit  <= 1'b1;
                            iload <= done_ok ? ramload : ERR_WORD;
                        end else begin
                            dhit <= 1'b1;
                            if (state_reg == DREAD) begin
                                dload <= done_ok ? ramload : ERR_WORD;
                            end
                        end
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    ramREN    <= 1'b0;
                    ramWEN    <= 1'b0;
                end
            endcase
        end
    end

    // Wait counter: cleared on grant, counts access cycles, saturates at TIMEOUT.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wait_cnt_reg <= '0;
        end else if (granting) begin
            wait_cnt_reg <= '0;
        end else if (in_access && (wait_cnt_reg != CNT_MAX)) begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
        end
    end

    // Fairness flag and sticky bus error.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fair_reg <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            if (granting && (grant_next == IREAD)) begin
                fair_reg <= 1'b0;
            end else if (done && is_data && iREN) begin
                fair_reg <= 1'b1;
            end
            if (done_err) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed testbench for mem_request_arbiter. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_mem_request_arbiter;

    localparam int DATA_W = 32;
    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_ERROR  = 2'd3;
    localparam logic [31:0] ERRW    = 32'hBAD1BAD1;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              iREN;
    logic [DATA_W-1:0] iaddr;
    logic [DATA_W-1:0] iload;
    logic              ihit;
    logic              dREN;
    logic              dWEN;
    logic [DATA_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic [DATA_W-1:0] dload;
    logic              dhit;
    logic              ramREN;
    logic              ramWEN;
    logic [DATA_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              bus_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    mem_request_arbiter #(.DATA_W(32), .TIMEOUT(15), .ERR_WORD(32'hBAD1BAD1)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
    );

    task automatic clear_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = S_FREE;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clear_inputs();
        @(negedge CLK);
        n_cmp++; if ({ihit, dhit, ramREN, ramWEN, bus_err} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 00000", {ihit, dhit, ramREN, ramWEN, bus_err}); end
        n_cmp++; if ({iload, dload, ramaddr, ramstore} !== 128'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {iload, dload, ramaddr, ramstore}); end
        nRST = 1'b1;
        @(negedge CLK);
        n_cmp++; if ({ihit, dhit, ramREN, ramWEN} !== 4'b0) begin n_fail++; $display("FAIL reset_idle: got %b want 0000", {ihit, dhit, ramREN, ramWEN}); end
        $display("test_reset done");
    endtask

    task automatic test_single_fetch();
        iREN = 1'b1; iaddr = 32'h40; ramstate = S_ACCESS; ramload = 32'h8C220004;
        @(negedge CLK);
        n_cmp++; if ({ramREN, ramWEN} !== 2'b10) begin n_fail++; $display("FAIL fetch_strobes: got %b want 10", {ramREN, ramWEN}); end
        n_cmp++; if (ramaddr !== 32'h40) begin n_fail++; $display("FAIL fetch_addr: got %h want 00000040", ramaddr); end
        n_cmp++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL fetch_early_hit: got %b want 0", ihit); end
        @(negedge CLK);
        n_cmp++; if ({ihit, dhit, ramREN} !== 3'b100) begin n_fail++; $display("FAIL fetch_hit: got ihit/dhit/ramREN %b want 100", {ihit, dhit, ramREN}); end
        n_cmp++; if (iload !== 32'h8C220004) begin n_fail++; $display("FAIL fetch_iload: got %h want 8c220004", iload); end
        iREN = 1'b0; ramstate = S_FREE;
        @(negedge CLK);
        n_cmp++; if ({ihit, ramREN} !== 2'b00) begin n_fail++; $display("FAIL fetch_single_pulse: got %b want 00", {ihit, ramREN}); end
        @(negedge CLK);
        n_cmp++; if (iload !== 32'h8C220004) begin n_fail++; $display("FAIL fetch_iload_hold: got %h want 8c220004", iload); end
        $display("test_single_fetch done");
    endtask

    task automatic test_simultaneous();
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100;
        ramstate = S_ACCESS; ramload = 32'h11112222;
        @(negedge CLK);
        n_cmp++; if (ramaddr !== 32'h100) begin n_fail++; $display("FAIL simul_data_first: got ramaddr %h want 00000100", ramaddr); end
        @(negedge CLK);
        n_cmp++; if ({ihit, dhit} !== 2'b01) begin n_fail++; $display("FAIL simul_dhit: got ihit/dhit %b want 01", {ihit, dhit}); end
        n_cmp++; if (dload !== 32'h11112222) begin n_fail++; $display("FAIL simul_dload: got %h want 11112222", dload); end
        ramload = 32'h33334444;
        @(negedge CLK);
        n_cmp++; if ({dhit, ramREN, ramWEN} !== 3'b000) begin n_fail++; $display("FAIL simul_resp_dead: got %b want 000", {dhit, ramREN, ramWEN}); end
        @(negedge CLK);
        n_cmp++; if ({ramREN, ramaddr} !== {1'b1, 32'h44}) begin n_fail++; $display("FAIL simul_fair_grant: got ramREN %b addr %h want 1 00000044", ramREN, ramaddr); end
        @(negedge CLK);
        n_cmp++; if ({ihit, dhit} !== 2'b10) begin n_fail++; $display("FAIL simul_ihit: got ihit/dhit %b want 10", {ihit, dhit}); end
        n_cmp++; if ({iload, dload} !== {32'h33334444, 32'h11112222}) begin n_fail++; $display("FAIL simul_loads: got %h %h want 33334444 11112222", iload, dload); end
        clear_inputs();
        @(negedge CLK);
        $display("test_simultaneous done");
    endtask

    task automatic test_write_priority_and_fair_clear();
        iREN = 1'b1; iaddr = 32'h4C; dREN = 1'b1; dWEN = 1'b1;
        daddr = 32'h300; dstore = 32'h55AA55AA; ramstate = S_ACCESS; ramload = 32'h66667777;
        @(negedge CLK);
        n_cmp++; if ({ramREN, ramWEN} !== 2'b01) begin n_fail++; $display("FAIL wpri_strobes: got %b want 01", {ramREN, ramWEN}); end
        n_cmp++; if ({ramaddr, ramstore} !== {32'h300, 32'h55AA55AA}) begin n_fail++; $display("FAIL wpri_bus: got %h %h want 00000300 55aa55aa", ramaddr, ramstore); end
        @(negedge CLK);
        n_cmp++; if ({dhit, dload} !== {1'b1, 32'h11112222}) begin n_fail++; $display("FAIL wpri_dhit: got %b %h want 1 11112222", dhit, dload); end
        dWEN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        n_cmp++; if ({ramREN, ramaddr} !== {1'b1, 32'h4C}) begin n_fail++; $display("FAIL wpri_fair_grant: got ramREN %b addr %h want 1 0000004c", ramREN, ramaddr); end
        @(negedge CLK);
        n_cmp++; if ({ihit, iload} !== {1'b1, 32'h66667777}) begin n_fail++; $display("FAIL wpri_ihit: got %b %h want 1 66667777", ihit, iload); end
        clear_inputs();
        @(negedge CLK);
        $display("test_write_priority_and_fair_clear done");
    endtask

    task automatic test_write_wait();
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF; ramstate = S_BUSY;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            n_cmp++; if ({ramWEN, ramREN, dhit} !== 3'b100) begin n_fail++; $display("FAIL wwait_strobes_%0d: got %b want 100", k, {ramWEN, ramREN, dhit}); end
            n_cmp++; if ({ramaddr, ramstore} !== {32'h200, 32'hDEADBEEF}) begin n_fail++; $display("FAIL wwait_bus_%0d: got %h %h want 00000200 deadbeef", k, ramaddr, ramstore); end
            daddr = 32'h999; dstore = 32'h0;
            if (k == 4) ramstate = S_ACCESS;
        end
        @(negedge CLK);
        n_cmp++; if ({dhit, ramWEN} !== 2'b10) begin n_fail++; $display("FAIL wwait_dhit: got %b want 10", {dhit, ramWEN}); end
        n_cmp++; if (dload !== 32'h11112222) begin n_fail++; $display("FAIL wwait_dload: got %h want 11112222", dload); end
        clear_inputs();
        @(negedge CLK);
        n_cmp++; if (dhit !== 1'b0) begin n_fail++; $display("FAIL wwait_single_pulse: got %b want 0", dhit); end
        $display("test_write_wait done");
    endtask

    task automatic test_ram_error();
        iREN = 1'b1; iaddr = 32'h48; ramstate = S_ERROR; ramload = 32'h12345678;
        @(negedge CLK);
        n_cmp++; if ({ramREN, bus_err} !== 2'b10) begin n_fail++; $display("FAIL rerr_access: got ramREN/bus_err %b want 10", {ramREN, bus_err}); end
        @(negedge CLK);
        n_cmp++; if ({ihit, iload} !== {1'b1, ERRW}) begin n_fail++; $display("FAIL rerr_ihit: got %b %h want 1 bad1bad1", ihit, iload); end
        n_cmp++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL rerr_bus_err: got %b want 1", bus_err); end
        clear_inputs();
        @(negedge CLK);
        n_cmp++; if ({ihit, bus_err} !== 2'b01) begin n_fail++; $display("FAIL rerr_sticky: got ihit/bus_err %b want 01", {ihit, bus_err}); end
        $display("test_ram_error done");
    endtask

    task automatic test_reset_mid_access();
        dREN = 1'b1; daddr = 32'h1C0; ramstate = S_BUSY;
        @(negedge CLK);
        @(negedge CLK);
        n_cmp++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL rmid_before: got ramREN %b want 1", ramREN); end
        #2 nRST = 1'b0;
        #1;
        n_cmp++; if ({ramREN, dhit, bus_err} !== 3'b000) begin n_fail++; $display("FAIL rmid_async: got ramREN/dhit/bus_err %b want 000", {ramREN, dhit, bus_err}); end
        clear_inputs();
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        n_cmp++; if ({ihit, dhit, ramREN, ramWEN, bus_err} !== 5'b0) begin n_fail++; $display("FAIL rmid_strobes: got %b want 00000", {ihit, dhit, ramREN, ramWEN, bus_err}); end
        n_cmp++; if ({iload, dload, ramaddr, ramstore} !== 128'h0) begin n_fail++; $display("FAIL rmid_data: got %h want 0", {iload, dload, ramaddr, ramstore}); end
        iREN = 1'b1; iaddr = 32'h50; ramstate = S_ACCESS; ramload = 32'h77;
        @(negedge CLK);
        n_cmp++; if ({ramREN, ramaddr} !== {1'b1, 32'h50}) begin n_fail++; $display("FAIL rmid_idle_grant: got %b %h want 1 00000050", ramREN, ramaddr); end
        @(negedge CLK);
        n_cmp++; if ({ihit, iload} !== {1'b1, 32'h77}) begin n_fail++; $display("FAIL rmid_ihit: got %b %h want 1 00000077", ihit, iload); end
        clear_inputs();
        @(negedge CLK);
        $display("test_reset_mid_access done");
    endtask

    task automatic test_timeout();
        n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL tmo_start_err: got %b want 0", bus_err); end
        dREN = 1'b1; daddr = 32'h180; ramstate = S_BUSY;
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            n_cmp++; if ({ramREN, dhit, bus_err} !== 3'b100) begin n_fail++; $display("FAIL tmo_wait_%0d: got ramREN/dhit/bus_err %b want 100", k, {ramREN, dhit, bus_err}); end
        end
        @(negedge CLK);
        n_cmp++; if ({dhit, ramREN} !== 2'b10) begin n_fail++; $display("FAIL tmo_dhit: got %b want 10", {dhit, ramREN}); end
        n_cmp++; if (dload !== ERRW) begin n_fail++; $display("FAIL tmo_dload: got %h want bad1bad1", dload); end
        n_cmp++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL tmo_bus_err: got %b want 1", bus_err); end
        daddr = 32'h104; ramstate = S_ACCESS; ramload = 32'h0A0B0C0D;
        @(negedge CLK);
        n_cmp++; if ({dhit, ramREN} !== 2'b00) begin n_fail++; $display("FAIL tmo_resp: got %b want 00", {dhit, ramREN}); end
        @(negedge CLK);
        n_cmp++; if ({ramREN, ramaddr} !== {1'b1, 32'h104}) begin n_fail++; $display("FAIL tmo_good_grant: got %b %h want 1 00000104", ramREN, ramaddr); end
        @(negedge CLK);
        n_cmp++; if ({dhit, dload} !== {1'b1, 32'h0A0B0C0D}) begin n_fail++; $display("FAIL tmo_good_dhit: got %b %h want 1 0a0b0c0d", dhit, dload); end
        clear_inputs();
        @(negedge CLK);
        n_cmp++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", bus_err); end
        $display("test_timeout done");
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_write_priority_and_fair_clear();
        test_write_wait();
        test_ram_error();
        test_reset_mid_access();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
